// File: rtl/bp_me_wb_client_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bp_me_wb_client_pkg
// Purpose : Shared types for the Wishbone <-> BedRock adapters. Holds the
//           BedRock memory header layout, the WB cti/bte encodings, the
//           client FSM state type and the sel -> {size, offset} decoder
//           so both WB adapters agree on one encoding.
// Revision: 1.0 - initial release
// ============================================================================
package bp_me_wb_client_pkg;

   // BP configuration slice used by the WB client
   localparam int paddr_width_gp   = 40;
   localparam int did_width_gp     = 4;
   localparam int lce_id_width_gp  = 4;
   localparam int lce_assoc_gp     = 8;
   localparam int way_id_width_gp  = $clog2(lce_assoc_gp);

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic [2:0]                 state;
      logic [way_id_width_gp-1:0] way_id;
      logic [lce_id_width_gp-1:0] lce_id;
      logic [did_width_gp-1:0]    did;
   } bp_bedrock_mem_payload_s;

   typedef struct packed {
      bp_bedrock_mem_payload_s    payload;
      bp_bedrock_msg_size_e       size;
      logic [paddr_width_gp-1:0]  addr;
      logic [3:0]                 subop;
      bp_bedrock_mem_type_e       msg_type;
   } bp_bedrock_mem_header_s;

   typedef enum logic [2:0] {
      e_wb_cti_classic = 3'd0,
      e_wb_cti_const   = 3'd1,
      e_wb_cti_incr    = 3'd2,
      e_wb_cti_eob     = 3'd7
   } wb_cti_e;

   typedef enum logic [1:0] {
      e_wb_bte_linear = 2'd0,
      e_wb_bte_wrap4  = 2'd1,
      e_wb_bte_wrap8  = 2'd2,
      e_wb_bte_wrap16 = 2'd3
   } wb_bte_e;

   typedef enum logic [1:0] {
      e_idle = 2'd0,
      e_send = 2'd1,
      e_wait = 2'd2,
      e_ack  = 2'd3
   } wb_client_state_e;

   typedef struct packed {
      logic       legal;
      logic [1:0] size_lg;   // log2 of access size in bytes
      logic [2:0] offset;    // byte offset of the access inside the bus word
   } sel_decode_s;

   // Only contiguous, naturally aligned masks are legal. Anything else
   // decodes as a full-bus access at offset 0 with legal cleared.
   function automatic sel_decode_s sel_decode(input logic [7:0] sel,
                                              input logic [1:0] bus_lg);
      sel_decode_s d;
      logic [7:0]  mask;
      int unsigned s;
      int unsigned bus_bytes;
      d.legal   = 1'b0;
      d.size_lg = bus_lg;
      d.offset  = 3'd0;
      bus_bytes = 32'd1 << bus_lg;
      for (int lg = 0; lg < 4; lg++) begin
         s = 32'd1 << lg;
         for (int k = 0; k < 8; k++) begin
            mask = 8'((32'd1 << s) - 32'd1) << k;
            if ((s <= bus_bytes) && ((32'(k) + s) <= bus_bytes)
                && ((32'(k) & (s - 32'd1)) == 32'd0) && (sel == mask)) begin
               d.legal   = 1'b1;
               d.size_lg = 2'(lg);
               d.offset  = 3'(k);
            end
         end
      end
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_me_wb_client_if.sv
`default_nettype none
// ============================================================================
// Module  : bp_me_wb_client_if
// Purpose : Bundles the Wishbone slave port and the BedRock mem_fwd/mem_rev
//           streams of the WB client. Modport slave is the client view,
//           modport master is the environment view (WB master + memory).
//           err_o exists only when BP_ME_WB_CLIENT_ERR_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
interface bp_me_wb_client_if
   import bp_me_wb_client_pkg::*;
#(
   parameter int data_width_p = 64
);
   localparam int bus_bytes_lp        = data_width_p >> 3;
   localparam int wbone_addr_width_lp = paddr_width_gp - $clog2(bus_bytes_lp);

   // Wishbone B4 classic
   logic [wbone_addr_width_lp-1:0] adr_i;
   logic [data_width_p-1:0]        dat_i;
   logic                           cyc_i;
   logic                           stb_i;
   logic [bus_bytes_lp-1:0]        sel_i;
   logic                           we_i;
   logic [data_width_p-1:0]        dat_o;
   logic                           ack_o;
`ifdef BP_ME_WB_CLIENT_ERR_EN
   logic                           err_o;
`endif

   // BedRock command / response
   bp_bedrock_mem_header_s         mem_fwd_header_o;
   logic [data_width_p-1:0]        mem_fwd_data_o;
   logic                           mem_fwd_v_o;
   logic                           mem_fwd_ready_and_i;
   logic                           mem_fwd_last_o;
   bp_bedrock_mem_header_s         mem_rev_header_i;
   logic [data_width_p-1:0]        mem_rev_data_i;
   logic                           mem_rev_v_i;
   logic                           mem_rev_ready_and_o;
   logic                           mem_rev_last_i;

   modport slave (
      input  adr_i, dat_i, cyc_i, stb_i, sel_i, we_i,
      output dat_o, ack_o,
`ifdef BP_ME_WB_CLIENT_ERR_EN
      output err_o,
`endif
      output mem_fwd_header_o, mem_fwd_data_o, mem_fwd_v_o, mem_fwd_last_o,
      input  mem_fwd_ready_and_i,
      input  mem_rev_header_i, mem_rev_data_i, mem_rev_v_i, mem_rev_last_i,
      output mem_rev_ready_and_o
   );

   modport master (
      output adr_i, dat_i, cyc_i, stb_i, sel_i, we_i,
      input  dat_o, ack_o,
`ifdef BP_ME_WB_CLIENT_ERR_EN
      input  err_o,
`endif
      input  mem_fwd_header_o, mem_fwd_data_o, mem_fwd_v_o, mem_fwd_last_o,
      output mem_fwd_ready_and_i,
      output mem_rev_header_i, mem_rev_data_i, mem_rev_v_i, mem_rev_last_i,
      input  mem_rev_ready_and_o
   );

endinterface
`default_nettype wire

// File: rtl/bp_me_wb_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : bp_me_wb_lane_align
// Purpose : Combinational byte-lane aligner. Shifts the access bytes found
//           at offset_i down to lane 0, then replicates that 2^size_lg_i byte
//           chunk across the whole bus (BedRock narrow-size convention).
//           With offset_i = 0 it acts as the read-side inverse: replicating
//           the LSB chunk lands it in every naturally aligned lane group,
//           including the selected one.
// Ports   : data_i    - input bus word
//           size_lg_i - log2 of access size in bytes
//           offset_i  - byte offset of the access
//           data_o    - aligned, replicated word
// Revision: 1.0 - initial release
// ============================================================================
module bp_me_wb_lane_align #(
   parameter int data_width_p = 64
) (
   input  logic [data_width_p-1:0] data_i,
   input  logic [1:0]              size_lg_i,
   input  logic [2:0]              offset_i,
   output logic [data_width_p-1:0] data_o
);
   localparam int bus_bytes_lp = data_width_p >> 3;

   logic [data_width_p-1:0] w_shifted;
   logic [63:0]             w_pad;
   logic [2:0]              w_mask;

   assign w_shifted = data_i >> {offset_i, 3'b000};
   assign w_pad     = 64'(w_shifted);
   // Byte i of the output takes chunk byte (i mod size); size is a power of 2.
   assign w_mask    = 3'((4'd1 << size_lg_i) - 4'd1);

   for (genvar i = 0; i < bus_bytes_lp; i++) begin : g_lane
      assign data_o[8*i +: 8] = w_pad[{3'(i) & w_mask, 3'b000} +: 8];
   end

endmodule
`default_nettype wire

// File: rtl/bp_me_wb_client.sv
`default_nettype none
// ============================================================================
// Module  : bp_me_wb_client
// Purpose : Wishbone B4 classic-cycle slave. Each WB access becomes one
//           single-beat BedRock uncached command on mem_fwd; the matching
//           mem_rev response returns as ack_o/dat_o.
// Ports   : clk_i, reset_n_i (async, active low)
//           wb - bp_me_wb_client_if.slave: WB adr/dat/cyc/stb/sel/we in,
//                dat_o/ack_o out, mem_fwd stream out, mem_rev stream in.
// Macro   : BP_ME_WB_CLIENT_ERR_EN - adds err_o; an illegal sel_i skips the
//           BedRock transaction and pulses err_o instead of ack_o. Without
//           it an illegal sel_i is issued as a full-bus access and flagged
//           by a simulation $error.
// Revision: 1.0 - initial release
// ============================================================================
module bp_me_wb_client
   import bp_me_wb_client_pkg::*;
#(
   parameter int data_width_p = 64,
   parameter int src_did_p    = 0
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   bp_me_wb_client_if.slave  wb
);
   localparam int bus_bytes_lp        = data_width_p >> 3;
   localparam int lg_bus_bytes_lp     = $clog2(bus_bytes_lp);
   localparam int wbone_addr_width_lp = paddr_width_gp - lg_bus_bytes_lp;

   wb_client_state_e               r_state, w_state_n;
   logic [wbone_addr_width_lp-1:0] r_adr;
   logic [data_width_p-1:0]        r_dat;
   logic                           r_we;
   logic [1:0]                     r_size_lg;
   logic [2:0]                     r_offset;
   logic                           r_abort;
   logic [data_width_p-1:0]        r_dat_o;
   logic                           w_err_flag;

   sel_decode_s                    w_dec_in;
   logic                           w_ack;
   logic                           w_start;
   bp_bedrock_mem_header_s         w_hdr;
   logic [data_width_p-1:0]        w_fwd_data;
   logic [data_width_p-1:0]        w_rev_data;

   assign w_dec_in = sel_decode(8'(wb.sel_i), 2'(lg_bus_bytes_lp));
   assign w_ack    = (r_state == e_ack) && !w_err_flag;
   assign w_start  = (r_state == e_idle) && wb.cyc_i && wb.stb_i && !w_ack;

   // Write path: selected lanes -> lane 0, replicated
   bp_me_wb_lane_align #(.data_width_p(data_width_p)) u_wr_align (
      .data_i    (r_dat),
      .size_lg_i (r_size_lg),
      .offset_i  (r_offset),
      .data_o    (w_fwd_data)
   );

   // Read path: memory already replicates, so re-replicating the LSB chunk
   // puts it in the selected lanes
   bp_me_wb_lane_align #(.data_width_p(data_width_p)) u_rd_align (
      .data_i    (wb.mem_rev_data_i),
      .size_lg_i (r_size_lg),
      .offset_i  (3'd0),
      .data_o    (w_rev_data)
   );

   always_comb begin
      w_hdr             = '0;
      w_hdr.msg_type    = r_we ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
      w_hdr.addr        = (paddr_width_gp'(r_adr) << lg_bus_bytes_lp)
                          | paddr_width_gp'(r_offset);
      w_hdr.size        = bp_bedrock_msg_size_e'({1'b0, r_size_lg});
      w_hdr.payload.did = did_width_gp'(src_did_p);
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         e_idle: begin
            if (w_start) begin
`ifdef BP_ME_WB_CLIENT_ERR_EN
               w_state_n = w_dec_in.legal ? e_send : e_ack;
`else
               w_state_n = e_send;
`endif
            end
         end
         e_send: if (wb.mem_fwd_ready_and_i) w_state_n = e_wait;
         // An abandoned cycle still drains its response, silently
         e_wait: if (wb.mem_rev_v_i)
                    w_state_n = (r_abort || !wb.cyc_i) ? e_idle : e_ack;
         e_ack:  w_state_n = e_idle;
         default: w_state_n = e_idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state   <= e_idle;
         r_adr     <= '0;
         r_dat     <= '0;
         r_we      <= 1'b0;
         r_size_lg <= 2'd0;
         r_offset  <= 3'd0;
         r_abort   <= 1'b0;
         r_dat_o   <= '0;
      end else begin
         r_state <= w_state_n;
         if (w_start) begin
            r_adr     <= wb.adr_i;
            r_dat     <= wb.dat_i;
            r_we      <= wb.we_i;
            r_size_lg <= w_dec_in.size_lg;
            r_offset  <= w_dec_in.offset;
            r_abort   <= 1'b0;
         end else if (((r_state == e_send) || (r_state == e_wait)) && !wb.cyc_i) begin
            r_abort <= 1'b1;
         end
         if ((r_state == e_wait) && wb.mem_rev_v_i) begin
            r_dat_o <= w_rev_data;
         end
      end
   end

`ifdef BP_ME_WB_CLIENT_ERR_EN
   logic r_err;
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_err <= 1'b0;
      end else if (w_start) begin
         r_err <= !w_dec_in.legal;
      end
   end
   assign w_err_flag = r_err;
   assign wb.err_o   = (r_state == e_ack) && r_err;
`else
   assign w_err_flag = 1'b0;
`endif

   assign wb.ack_o               = w_ack;
   assign wb.dat_o               = r_dat_o;
   assign wb.mem_fwd_header_o    = w_hdr;
   assign wb.mem_fwd_data_o      = w_fwd_data;
   assign wb.mem_fwd_v_o         = (r_state == e_send);
   assign wb.mem_fwd_last_o      = 1'b1;
   assign wb.mem_rev_ready_and_o = (r_state == e_wait);

   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (data_width_p == 8 || data_width_p == 16
                 || data_width_p == 32 || data_width_p == 64)
            else $error("bp_me_wb_client: unsupported data_width_p %0d", data_width_p);
         if ((r_state == e_wait) && wb.mem_rev_v_i) begin
            assert (wb.mem_rev_last_i)
               else $error("bp_me_wb_client: mem_rev_last_i low on a response");
            assert (wb.mem_rev_header_i.msg_type == w_hdr.msg_type)
               else $error("bp_me_wb_client: response msg_type does not match command");
         end
`ifndef BP_ME_WB_CLIENT_ERR_EN
         if (w_start) begin
            assert (w_dec_in.legal)
               else $error("bp_me_wb_client: illegal sel_i %h", wb.sel_i);
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bp_me_wb_client.sv
`default_nettype none
// ============================================================================
// Module  : tb_bp_me_wb_client
// Purpose : Self-checking bench for bp_me_wb_client (64-bit bus). Acts as
//           the WB master and the BedRock memory; a behavioural model derives
//           header, command data and read data from sel/adr/dat, and a
//           per-cycle compare process checks the handshake outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bp_me_wb_client;
   import bp_me_wb_client_pkg::*;

   localparam int SRC_DID = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bp_me_wb_client_if #(.data_width_p(64)) bus ();

   bp_me_wb_client #(.data_width_p(64), .src_did_p(SRC_DID)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .wb        (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Expectations maintained by the stimulus, read by the compare process
   bit                     cmd_live    = 1'b0;
   bit                     rsp_wait    = 1'b0;
   bit                     ack_allowed = 1'b0;
   bit                     err_allowed = 1'b0;
   bit                     exp_we      = 1'b0;
   bp_bedrock_mem_header_s exp_hdr;
   logic [63:0]            exp_data;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [63:0] rep(input logic [63:0] v, input int nbytes);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(i % nbytes) +: 8];
      return r;
   endfunction

   function automatic int low_lane(input logic [7:0] sel);
      for (int i = 0; i < 8; i++) if (sel[i]) return i;
      return 0;
   endfunction

   function automatic bp_bedrock_mem_header_s model_hdr(input logic [36:0] adr,
         input logic [7:0] sel, input bit we);
      bp_bedrock_mem_header_s h;
      int n;
      n = $countones(sel);
      h = '0;
      h.msg_type    = we ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
      h.addr        = {3'b000, adr, 3'(low_lane(sel))};
      h.size        = (n == 1) ? e_bedrock_msg_size_1 : (n == 2) ? e_bedrock_msg_size_2 :
                      (n == 4) ? e_bedrock_msg_size_4 : e_bedrock_msg_size_8;
      h.payload.did = 4'(SRC_DID);
      return h;
   endfunction

   // ---------------- per-cycle compare ----------------
   always begin
      @(posedge clk);
      #2;
      if (reset_n) begin
         chk("fwd_v", 128'(bus.mem_fwd_v_o), 128'(cmd_live));
         chk("rev_ready", 128'(bus.mem_rev_ready_and_o), 128'(rsp_wait));
         chk("ack", 128'(bus.ack_o), 128'(ack_allowed));
`ifdef BP_ME_WB_CLIENT_ERR_EN
         chk("err", 128'(bus.err_o), 128'(err_allowed));
`endif
         if (bus.mem_fwd_v_o && cmd_live) begin
            chk("fwd_hdr", 128'(bus.mem_fwd_header_o), 128'(exp_hdr));
            chk("fwd_last", 128'(bus.mem_fwd_last_o), 128'(1'b1));
            if (exp_we) chk("fwd_data", 128'(bus.mem_fwd_data_o), 128'(exp_data));
         end
      end
   end

   // ---------------- one WB transaction ----------------
   // abort_ph: 0 none, 1 drop cyc in SEND, 2 drop cyc in WAIT
   task automatic run_txn(input logic [36:0] adr, input logic [7:0] sel, input bit we,
         input logic [63:0] wdat, input logic [63:0] rraw, input int fwd_delay,
         input int rev_delay, input int abort_ph, output bp_bedrock_mem_header_s got_hdr,
         output logic [63:0] got_fwd_data, output logic [63:0] got_dat_o);
      int n;
      int lat;
      bit hs;
      logic [63:0] exp_rd;
      got_hdr = '0; got_fwd_data = '0; got_dat_o = '0;
      exp_rd = rep(rraw, $countones(sel));
      @(negedge clk);
      exp_hdr  = model_hdr(adr, sel, we);
      exp_data = rep(wdat >> (8 * low_lane(sel)), $countones(sel));
      exp_we   = we;
      bus.adr_i = adr; bus.sel_i = sel; bus.we_i = we; bus.dat_i = wdat;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
      cmd_live = 1'b1;
      n = 0; lat = 0; hs = 1'b0;
      while (!hs) begin
         @(negedge clk);
         n++; lat++;
         if (n == 1) chk("fwd_latency", 128'(bus.mem_fwd_v_o), 128'(1'b1));
         if (n > 100) begin
            $display("FAIL fwd_timeout: got no handshake expected one within 100 cycles");
            $fatal(1, "timeout");
         end
         if (abort_ph == 1 && n == 1) begin bus.cyc_i = 1'b0; bus.stb_i = 1'b0; end
         if (n > fwd_delay) begin
            bus.mem_fwd_ready_and_i = 1'b1;
            if (bus.mem_fwd_v_o) begin
               got_hdr = bus.mem_fwd_header_o; got_fwd_data = bus.mem_fwd_data_o;
               hs = 1'b1; cmd_live = 1'b0; rsp_wait = 1'b1;
            end
         end else begin
            bus.mem_fwd_ready_and_i = 1'b0;
         end
      end
      for (int i = 0; ; i++) begin
         @(negedge clk);
         lat++;
         bus.mem_fwd_ready_and_i = 1'b0;
         if (abort_ph == 2 && i == 0) begin bus.cyc_i = 1'b0; bus.stb_i = 1'b0; end
         if (i >= rev_delay) begin
            bus.mem_rev_v_i = 1'b1; bus.mem_rev_data_i = rraw; bus.mem_rev_last_i = 1'b1;
            bus.mem_rev_header_i = '0;
            bus.mem_rev_header_i.msg_type = exp_hdr.msg_type;
            rsp_wait = 1'b0; ack_allowed = (abort_ph == 0);
            break;
         end
      end
      @(negedge clk);
      lat++;
      bus.mem_rev_v_i = 1'b0;
      if (abort_ph == 0) begin
         chk("ack_pulse", 128'(bus.ack_o), 128'(1'b1));
         chk("dat_o", 128'(bus.dat_o), 128'(exp_rd));
         chk("ack_latency_ge3", 128'(lat >= 3), 128'(1'b1));
         got_dat_o = bus.dat_o;
         bus.cyc_i = 1'b0; bus.stb_i = 1'b0; ack_allowed = 1'b0;
      end else begin
         chk("abort_no_ack", 128'(bus.ack_o), 128'(1'b0));
      end
      @(negedge clk);
   endtask

   initial begin
      bp_bedrock_mem_header_s h;
      logic [63:0] fd, dd, wd, rr;
      logic [36:0] a;
      logic [7:0]  s;
      int lg, sz, ab;

      bus.adr_i = '0; bus.dat_i = '0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      bus.sel_i = '0; bus.we_i = 1'b0; bus.mem_fwd_ready_and_i = 1'b0;
      bus.mem_rev_header_i = '0; bus.mem_rev_data_i = '0; bus.mem_rev_v_i = 1'b0;
      bus.mem_rev_last_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ack", 128'(bus.ack_o), 128'(1'b0));
      chk("reset_dat_o", 128'(bus.dat_o), 128'(0));
      chk("reset_fwd_v", 128'(bus.mem_fwd_v_o), 128'(1'b0));
      chk("reset_rev_ready", 128'(bus.mem_rev_ready_and_o), 128'(1'b0));
      reset_n = 1'b1;

      // Write 8 bytes
      run_txn(37'h10, 8'hFF, 1'b1, 64'h1122334455667788, 64'h0, 0, 0, 0, h, fd, dd);
      chk("w8_type", 128'(h.msg_type), 128'(e_bedrock_mem_uc_wr));
      chk("w8_addr", 128'(h.addr), 128'(40'h80));
      chk("w8_size", 128'(h.size), 128'(e_bedrock_msg_size_8));
      chk("w8_data", 128'(fd), 128'(64'h1122334455667788));

      // Write 1 byte at lane 5
      run_txn(37'h10, 8'h20, 1'b1, 64'h0000AB0000000000, 64'h0, 0, 1, 0, h, fd, dd);
      chk("w1_addr", 128'(h.addr), 128'(40'h85));
      chk("w1_size", 128'(h.size), 128'(e_bedrock_msg_size_1));
      chk("w1_data", 128'(fd), 128'(64'hABABABABABABABAB));

      // Read 4 bytes, upper half
      run_txn(37'h10, 8'hF0, 1'b0, 64'h0, 64'hDEADBEEFDEADBEEF, 0, 0, 0, h, fd, dd);
      chk("r4_type", 128'(h.msg_type), 128'(e_bedrock_mem_uc_rd));
      chk("r4_addr", 128'(h.addr), 128'(40'h84));
      chk("r4_size", 128'(h.size), 128'(e_bedrock_msg_size_4));
      chk("r4_did", 128'(h.payload.did), 128'(4'd5));
      chk("r4_dat_hi", 128'(dd[63:32]), 128'(32'hDEADBEEF));

      // Back-pressure on mem_fwd for 5 cycles
      run_txn(37'h123, 8'h0C, 1'b1, 64'h00000000CAFE0000, 64'h0, 5, 2, 0, h, fd, dd);
      chk("bp_data", 128'(fd), 128'(64'hCAFECAFECAFECAFE));

      // Abort in WAIT, then a normal access
      run_txn(37'h40, 8'h03, 1'b0, 64'h0, 64'h5555, 0, 2, 2, h, fd, dd);
      run_txn(37'h41, 8'h01, 1'b0, 64'h0, 64'h77, 0, 0, 0, h, fd, dd);
      chk("post_abort_dat", 128'(dd), 128'(64'h7777777777777777));

      // Asynchronous reset while in SEND
      @(negedge clk);
      exp_hdr = model_hdr(37'h8, 8'hFF, 1'b1); exp_data = 64'h99; exp_we = 1'b1;
      bus.adr_i = 37'h8; bus.sel_i = 8'hFF; bus.we_i = 1'b1; bus.dat_i = 64'h99;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; cmd_live = 1'b1;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_fwd_v", 128'(bus.mem_fwd_v_o), 128'(1'b0));
      chk("arst_ack", 128'(bus.ack_o), 128'(1'b0));
      chk("arst_dat_o", 128'(bus.dat_o), 128'(0));
      chk("arst_rev_ready", 128'(bus.mem_rev_ready_and_o), 128'(1'b0));
      cmd_live = 1'b0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      run_txn(37'h8, 8'hFF, 1'b0, 64'h0, 64'h0123456789ABCDEF, 1, 1, 0, h, fd, dd);

`ifdef BP_ME_WB_CLIENT_ERR_EN
      // Illegal selects: err_o pulse, no BedRock traffic
      foreach (s[i]) begin end
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         bus.sel_i = (t == 0) ? 8'h00 : (t == 1) ? 8'h5A : 8'h06;
         bus.adr_i = 37'h3; bus.we_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
         err_allowed = 1'b1;
         @(negedge clk);
         chk("err_pulse", 128'(bus.err_o), 128'(1'b1));
         chk("err_no_ack", 128'(bus.ack_o), 128'(1'b0));
         bus.cyc_i = 1'b0; bus.stb_i = 1'b0; err_allowed = 1'b0;
         @(negedge clk);
      end
`endif

      // Randomized legal accesses
      for (int t = 0; t < 40; t++) begin
         lg = $urandom_range(0, 3);
         sz = 1 << lg;
         s  = 8'(((1 << sz) - 1) << ($urandom_range(0, 8 / sz - 1) * sz));
         a  = 37'({$urandom(), $urandom()});
         wd = {$urandom(), $urandom()};
         rr = {$urandom(), $urandom()};
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
         run_txn(a, s, 1'($urandom_range(0, 1)), wd, rr, $urandom_range(0, 3),
                 $urandom_range(0, 3), ab, h, fd, dd);
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
